// File: rtl/prog_loader.sv
// Streaming program loader: header-directed writes into IMEM, DMEM (bytewise) and the RF, then releases the CPU.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN gates RUN on a 16-bit checksum of the loaded data words.
module prog_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [7:0]  dmem_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 14;
    localparam int unsigned RW = 5;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DBYTE, S_RUN} state_t;
    typedef enum logic [1:0] {T_IMEM = 2'b00, T_DMEM = 2'b01, T_RF = 2'b10, T_RUN = 2'b11} target_t;

    state_t          state_q, state_d;
    logic [1:0]      tgt_q, tgt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   word_q, word_d;
    logic [1:0]      byte_q, byte_d;
    logic            in_ready_d, imem_we_d, dmem_we_d, rf_we_d, cpu_hold_d, done_d;
    logic [AW-1:0]   imem_addr_d, dmem_addr_d;
    logic [DW-1:0]   imem_wdata_d, rf_wdata_d;
    logic [7:0]      dmem_wdata_d;
    logic [RW-1:0]   rf_addr_d;
    logic            fire;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [AW-1:0]   csum_q, csum_d;
    logic            err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign fire = in_valid && in_ready;

    // Next-state and next-output computation; write enables default to a single-cycle pulse.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        word_d       = word_q;
        byte_d       = byte_q;
        imem_we_d    = 1'b0;
        dmem_we_d    = 1'b0;
        rf_we_d      = 1'b0;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        dmem_addr_d  = dmem_addr;
        dmem_wdata_d = dmem_wdata;
        rf_addr_d    = rf_addr;
        rf_wdata_d   = rf_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    if (in_data[31:30] == T_RUN) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        if (in_data[15:0] == csum_q) state_d = S_RUN;
                        else                         err_d   = 1'b1;
`else
                        state_d = S_RUN;
`endif
                    end else if (in_data[29:16] != '0) begin
                        tgt_d   = in_data[31:30];
                        cnt_d   = in_data[29:16];
                        addr_d  = in_data[15:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    cnt_d = cnt_q - CW'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_q + in_data[15:0];
`endif
                    case (tgt_q)
                        T_IMEM: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = addr_q;
                            imem_wdata_d = in_data;
                            addr_d       = addr_q + AW'(4);
                            if (cnt_q == CW'(1)) state_d = S_IDLE;
                        end
                        T_RF: begin
                            rf_we_d     = (addr_q[4:0] != '0);
                            rf_addr_d   = addr_q[4:0];
                            rf_wdata_d  = in_data;
                            addr_d[4:0] = addr_q[4:0] + RW'(1);
                            if (cnt_q == CW'(1)) state_d = S_IDLE;
                        end
                        T_DMEM: begin
                            dmem_we_d    = 1'b1;
                            dmem_addr_d  = addr_q;
                            dmem_wdata_d = in_data[31:24];
                            word_d       = {in_data[23:0], 8'h00};
                            byte_d       = 2'd0;
                            state_d      = S_DBYTE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_DBYTE: begin
                // byte_q names the byte currently on the port; the last one closes the word.
                if (byte_q == 2'd3) begin
                    addr_d  = addr_q + AW'(4);
                    state_d = (cnt_q == '0) ? S_IDLE : S_DATA;
                end else begin
                    dmem_we_d    = 1'b1;
                    dmem_addr_d  = dmem_addr + AW'(1);
                    dmem_wdata_d = word_q[31:24];
                    word_d       = {word_q[23:0], 8'h00};
                    byte_d       = byte_q + 2'd1;
                end
            end
            default: ;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_DATA);
        cpu_hold_d = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tgt_q      <= 2'b00;
            cnt_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            byte_q     <= 2'd0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            in_ready   <= in_ready_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            dmem_we    <= dmem_we_d;
            dmem_addr  <= dmem_addr_d;
            dmem_wdata <= dmem_wdata_d;
            rf_we      <= rf_we_d;
            rf_addr    <= rf_addr_d;
            rf_wdata   <= rf_wdata_d;
            cpu_hold   <= cpu_hold_d;
            done       <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            err_q      <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader; one row per clock with hand-computed expected outputs.
module tb_prog_loader;
    logic        clk, reset, in_valid, in_ready;
    logic [31:0] in_data;
    logic        imem_we, dmem_we, rf_we, cpu_hold, done, err;
    logic [15:0] imem_addr, dmem_addr;
    logic [31:0] imem_wdata, rf_wdata;
    logic [7:0]  dmem_wdata;
    logic [4:0]  rf_addr;

    int errors = 0;
    int checks = 0;

    // Expected write kind: 0 none, 1 imem, 2 dmem, 3 rf.
    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] data;
        logic        e_ready;
        logic        e_hold;
        logic        e_done;
        logic        e_err;
        int          e_kind;
        logic [15:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[$];

    prog_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic vld, input logic [31:0] data,
                       input logic rdy, input logic hold, input logic dn, input logic er,
                       input int kind, input logic [15:0] addr, input logic [31:0] wdata);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = data;
        v.e_ready = rdy; v.e_hold = hold; v.e_done = dn; v.e_err = er;
        v.e_kind = kind; v.e_addr = addr; v.e_wdata = wdata;
        tbl.push_back(v);
    endtask

    task automatic step(input logic rst, input logic vld, input logic [31:0] data);
        reset = rst; in_valid = vld; in_data = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0;

        // Per-clock rows: inputs driven for one cycle, outputs expected just after the edge.
        add(1, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        // IMEM load of two words from 0x0000
        add(0, 1, 32'h0002_0000, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h2008_0005, 1, 1, 0, 0, 1, 16'h0000, 32'h2008_0005);
        add(0, 1, 32'h2009_0007, 1, 1, 0, 0, 1, 16'h0004, 32'h2009_0007);
        add(0, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        // DMEM load: one word split big-endian over four cycles
        add(0, 1, 32'h4001_0008, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'hAABB_CCDD, 0, 1, 0, 0, 2, 16'd8,    32'hAA);
        add(0, 0, 32'h0,         0, 1, 0, 0, 2, 16'd9,    32'hBB);
        add(0, 1, 32'h5555_5555, 0, 1, 0, 0, 2, 16'd10,   32'hCC);
        add(0, 0, 32'h0,         0, 1, 0, 0, 2, 16'd11,   32'hDD);
        add(0, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        // RF load from r31 wrapping to r0 (suppressed) and r1
        add(0, 1, 32'h8003_001F, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0000_0001, 1, 1, 0, 0, 3, 16'd31,   32'h1);
        add(0, 1, 32'h0000_0002, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0000_0003, 1, 1, 0, 0, 3, 16'd1,    32'h3);
        add(0, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        // IMEM address wrap with valid gaps
        add(0, 1, 32'h0002_FFFC, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 0, 32'hDEAD_BEEF, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h1111_1111, 1, 1, 0, 0, 1, 16'hFFFC, 32'h1111_1111);
        add(0, 0, 32'h9999_9999, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h2222_2222, 1, 1, 0, 0, 1, 16'h0000, 32'h2222_2222);
        // count=0 header: stays idle, then a data-looking word must not write
        add(0, 1, 32'h0000_0040, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0000_1234, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        // Reset in the middle of a DMEM word abandons the remaining bytes
        add(0, 1, 32'h4002_0100, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0102_0304, 0, 1, 0, 0, 2, 16'h0100, 32'h01);
        add(0, 0, 32'h0,         0, 1, 0, 0, 2, 16'h0101, 32'h02);
        add(1, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum mismatch holds the CPU and flags err; reset clears both
        add(1, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0001_0000, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0000_1234, 1, 1, 0, 0, 1, 16'h0000, 32'h0000_1234);
        add(0, 1, 32'hC000_1235, 1, 1, 0, 1, 0, 16'h0,    32'h0);
        add(1, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0001_0000, 1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0000_1234, 1, 1, 0, 0, 1, 16'h0000, 32'h0000_1234);
        add(0, 1, 32'hC000_1234, 0, 0, 1, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0001_0000, 0, 0, 1, 0, 0, 16'h0,    32'h0);
        add(1, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
`else
        // RUN releases the CPU and ignores further input until reset
        add(0, 1, 32'hC000_0000, 0, 0, 1, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h0001_0000, 0, 0, 1, 0, 0, 16'h0,    32'h0);
        add(0, 1, 32'h1234_5678, 0, 0, 1, 0, 0, 16'h0,    32'h0);
        add(1, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
        add(0, 0, 32'h0,         1, 1, 0, 0, 0, 16'h0,    32'h0);
`endif

        // Reset values of every address/data output
        step(1, 0, 32'h0);
        chk("rst_imem_addr",  -1, 32'(imem_addr),  32'h0);
        chk("rst_imem_wdata", -1, imem_wdata,      32'h0);
        chk("rst_dmem_addr",  -1, 32'(dmem_addr),  32'h0);
        chk("rst_dmem_wdata", -1, 32'(dmem_wdata), 32'h0);
        chk("rst_rf_addr",    -1, 32'(rf_addr),    32'h0);
        chk("rst_rf_wdata",   -1, rf_wdata,        32'h0);
        chk("rst_in_ready",   -1, 32'(in_ready),   32'h1);
        chk("rst_cpu_hold",   -1, 32'(cpu_hold),   32'h1);

        // Long stall mid-DATA: no writes, no timeout, then the word lands
        step(0, 1, 32'h0001_0040);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 32'hFFFF_FFFF);
            chk("stall_we", i, 32'({imem_we, dmem_we, rf_we}), 32'h0);
            chk("stall_ready", i, 32'(in_ready), 32'h1);
        end
        step(0, 1, 32'hCAFE_F00D);
        chk("stall_imem_we",    -1, 32'(imem_we),   32'h1);
        chk("stall_imem_addr",  -1, 32'(imem_addr), 32'h40);
        chk("stall_imem_wdata", -1, imem_wdata,     32'hCAFE_F00D);

        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r].rst, tbl[r].vld, tbl[r].data);
            chk("in_ready", r, 32'(in_ready), 32'(tbl[r].e_ready));
            chk("cpu_hold", r, 32'(cpu_hold), 32'(tbl[r].e_hold));
            chk("done",     r, 32'(done),     32'(tbl[r].e_done));
            chk("err",      r, 32'(err),      32'(tbl[r].e_err));
            chk("imem_we",  r, 32'(imem_we),  32'(tbl[r].e_kind == 1));
            chk("dmem_we",  r, 32'(dmem_we),  32'(tbl[r].e_kind == 2));
            chk("rf_we",    r, 32'(rf_we),    32'(tbl[r].e_kind == 3));
            case (tbl[r].e_kind)
                1: begin
                    chk("imem_addr",  r, 32'(imem_addr), 32'(tbl[r].e_addr));
                    chk("imem_wdata", r, imem_wdata,     tbl[r].e_wdata);
                end
                2: begin
                    chk("dmem_addr",  r, 32'(dmem_addr),  32'(tbl[r].e_addr));
                    chk("dmem_wdata", r, 32'(dmem_wdata), tbl[r].e_wdata);
                end
                3: begin
                    chk("rf_addr",  r, 32'(rf_addr), 32'(tbl[r].e_addr));
                    chk("rf_wdata", r, rf_wdata,     tbl[r].e_wdata);
                end
                default: ;
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
